// File: rtl/branch_logic.sv
// rtl/branch_logic.sv - MIPS branch decision with a registered PC-mux select
// Optional taken-branch counter enabled by defining BRANCH_LOGIC_STATS_EN.
module branch_logic #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  branch_en,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [1:0]            branch_cntrl,
  input  logic                  zero,
  output logic                  branch_cond,
  output logic                  branch_out
`ifdef BRANCH_LOGIC_STATS_EN
  ,
  output logic [31:0]           branch_count
`endif
);

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_BGEZ = 2'b10,
    BR_BLTZ = 2'b11
  } br_type_e;

  br_type_e br_type;
  logic     rs_neg;
  logic     unused_rs_low;

  assign br_type       = br_type_e'(branch_cntrl);
  // Only the sign bit matters for BGEZ/BLTZ; the magnitude bits are deliberately ignored.
  assign rs_neg        = rs[DATA_WIDTH-1];
  assign unused_rs_low = ^rs[DATA_WIDTH-2:0];

  always_comb begin
    branch_cond = 1'b0;
    if (branch_en) begin
      case (br_type)
        BR_BEQ:  branch_cond = zero;
        BR_BNE:  branch_cond = ~zero;
        BR_BGEZ: branch_cond = ~rs_neg;
        BR_BLTZ: branch_cond = rs_neg;
        default: branch_cond = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      branch_out <= 1'b0;
    end else begin
      branch_out <= branch_cond;
    end
  end

`ifdef BRANCH_LOGIC_STATS_EN
  logic [31:0] count_q;

  // Saturating so a long-running profile never reads back as a small number.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= 32'd0;
    end else if (branch_cond && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign branch_count = count_q;
`endif

endmodule

// File: tb/tb_branch_logic.sv
// tb/tb_branch_logic.sv - self-checking bench for branch_logic
// Counter checks are compiled only when BRANCH_LOGIC_STATS_EN is defined.
module tb_branch_logic;

  logic        Clk;
  logic        Rst_n;
  logic        branch_en;
  logic [31:0] rs;
  logic [1:0]  branch_cntrl;
  logic        zero;
  logic        branch_cond;
  logic        branch_out;
`ifdef BRANCH_LOGIC_STATS_EN
  logic [31:0] branch_count;
`endif

  int          checks;
  int          failures;
  logic [31:0] exp_count;

  branch_logic #(.DATA_WIDTH(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .branch_en    (branch_en),
    .rs           (rs),
    .branch_cntrl (branch_cntrl),
    .zero         (zero),
    .branch_cond  (branch_cond),
    .branch_out   (branch_out)
`ifdef BRANCH_LOGIC_STATS_EN
    ,
    .branch_count (branch_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference decision straight from the branch semantics, using signed compares.
  function automatic logic model(input logic en, input logic [1:0] code,
                                 input logic [31:0] r, input logic z);
    if (!en) return 1'b0;
    case (code)
      2'd0:    return z == 1'b1;
      2'd1:    return z == 1'b0;
      2'd2:    return $signed(r) >= 0;
      default: return $signed(r) < 0;
    endcase
  endfunction

  task automatic check_count(input string name);
`ifdef BRANCH_LOGIC_STATS_EN
    checks++;
    if (branch_count !== exp_count) begin
      failures++;
      $display("FAIL %s branch_count: got %h expected %h", name, branch_count, exp_count);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic step(input logic en, input logic [1:0] code, input logic [31:0] r,
                      input logic z, input string name);
    logic exp;
    @(negedge Clk);
    branch_en = en; branch_cntrl = code; rs = r; zero = z;
    #1;
    exp = model(en, code, r, z);
    checks++;
    if (branch_cond !== exp) begin
      failures++;
      $display("FAIL %s branch_cond: got %b expected %b (en=%b code=%b rs=%h zero=%b)",
               name, branch_cond, exp, en, code, r, z);
    end
    @(posedge Clk);
    #1;
    if (exp && exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 32'd1;
    checks++;
    if (branch_out !== exp) begin
      failures++;
      $display("FAIL %s branch_out: got %b expected %b", name, branch_out, exp);
    end
    check_count(name);
  endtask

  task automatic quick_reset();
    @(negedge Clk);
    branch_en = 1'b0;
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
    exp_count = 32'd0;
  endtask

  task automatic test_reset();
    branch_en = 1'b1; branch_cntrl = 2'b00; rs = 32'h0; zero = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    exp_count = 32'd0;
    checks++;
    if (branch_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_async branch_out: got %b expected 0", branch_out);
    end
    check_count("reset_async");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    exp_count = 32'd1;
    checks++;
    if (branch_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_release branch_out: got %b expected 1", branch_out);
    end
    check_count("reset_release");
  endtask

  task automatic test_decision_table();
    logic [31:0] vals [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hF000_0000,
                              32'h0000_0020, 32'h7FFF_FFFF};
    for (int v = 0; v < 5; v++)
      for (int c = 0; c < 4; c++) step(1'b1, 2'(c), vals[v], 1'b0, "table_zero0");
    step(1'b1, 2'b10, 32'h8000_0000, 1'b1, "bgez_min_neg");
    step(1'b1, 2'b11, 32'h8000_0000, 1'b1, "bltz_min_neg");
    for (int c = 0; c < 4; c++) step(1'b1, 2'(c), 32'h0, 1'b1, "table_zero1");
  endtask

  task automatic test_branch_en_off();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 2'(c), 32'h0, 1'b1, "en_off_zero1");
      step(1'b0, 2'(c), 32'h8000_0000, 1'b0, "en_off_neg");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 32'h7FFF_FFFF;
        1:       r = 32'h8000_0000;
        default: r = $urandom;
      endcase
      step(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), r,
           1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_stats();
`ifdef BRANCH_LOGIC_STATS_EN
    quick_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 32'h0, 1'b0, "stats_bne");
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'h0, 1'b0, "stats_beq");
    checks++;
    if (branch_count !== 32'd5) begin
      failures++;
      $display("FAIL stats_five branch_count: got %0d expected 5", branch_count);
    end
    @(negedge Clk);
    branch_en = 1'b0;
    dut.count_q = 32'hFFFF_FFFD;
    exp_count = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 32'h8000_0000, 1'b0, "stats_saturate");
`endif
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'b10, 32'h0000_0005, 1'b0, "async_setup");
    branch_en = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    exp_count = 32'd0;
    checks++;
    if (branch_out !== 1'b0) begin
      failures++;
      $display("FAIL async_midcycle branch_out: got %b expected 0", branch_out);
    end
    check_count("async_midcycle");
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1'b1, 2'b01, 32'h0, 1'b0, "after_async");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 32'd0;
    Rst_n = 1'b1;
    branch_en = 1'b0; branch_cntrl = 2'b00; rs = 32'h0; zero = 1'b0;
    test_reset();
    test_decision_table();
    test_branch_en_off();
    test_back_to_back();
    test_stats();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
